// File: rtl/alu_arbiter.sv
// Purpose: round-robin share of one registered 16-bit ALU between two valid/ready requesters; one op in flight.
// Latency: accept edge -> rsp_valid three cycles later; at most one operation every four cycles.
// Backpressure: req*_ready only in IDLE; rsp_* held stable while rsp_valid && !rsp_ready.
//
// Ports:
//   clock, reset_n                 rising-edge clock, async active-low reset
//   req{0,1}_valid/_ready/_op/_a/_b request channels (op: 000 add, 001 sub, 010 and, 011 or, 100 slt)
//   rsp_valid/_ready/_id/_result/_zero/_overflow/_err  response channel
//   alu_a, alu_b, alu_ctrl         registered operands/control towards the ALU
//   alu_result, alu_overflow, alu_slt  registered ALU outputs
//   busy                           an operation is in flight (state != IDLE)
module alu_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    input  logic             alu_slt,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_CAPT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SLT = 3'b100;

    logic [1:0]       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             id_q, id_d;
    logic [2:0]       op_q, op_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_ctrl_q, alu_ctrl_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_overflow_q, rsp_overflow_d;
    logic             rsp_err_q, rsp_err_d;

    logic             idle;
    logic             gnt_vld;
    logic             gnt_id;
    logic [2:0]       gnt_op;
    logic [WIDTH-1:0] gnt_a;
    logic [WIDTH-1:0] gnt_b;
    logic             gnt_illegal;
    logic [WIDTH-1:0] capt_result;

    // Grant selection and ready generation.
    always_comb begin
        idle    = (state_q == ST_IDLE);
        gnt_vld = req0_valid | req1_valid;
        // On a tie the requester that did not win last time goes next;
        // otherwise whichever one is asking (req1_valid alone -> 1).
        if (req0_valid && req1_valid) begin
            gnt_id = ~last_grant_q;
        end else begin
            gnt_id = req1_valid;
        end
        gnt_op      = gnt_id ? req1_op : req0_op;
        gnt_a       = gnt_id ? req1_a  : req0_a;
        gnt_b       = gnt_id ? req1_b  : req0_b;
        gnt_illegal = gnt_op[2] & (|gnt_op[1:0]);
        // reset_n gates the readies so they read 0 while reset is held,
        // even though state_q already sits at IDLE.
        req0_ready  = reset_n & idle & gnt_vld & ~gnt_id;
        req1_ready  = reset_n & idle & gnt_vld &  gnt_id;
    end

    // Result formatting for the capture edge.
    always_comb begin
        if (illegal_q) begin
            capt_result = '0;
        end else if (op_q == OP_SLT) begin
            capt_result = {{(WIDTH-1){1'b0}}, alu_slt};
        end else begin
            capt_result = alu_result;
        end
    end

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        id_d           = id_q;
        op_d           = op_q;
        illegal_d      = illegal_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_ctrl_d     = alu_ctrl_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_id_d       = rsp_id_q;
        rsp_result_d   = rsp_result_q;
        rsp_zero_d     = rsp_zero_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_err_d      = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    alu_a_d      = gnt_a;
                    alu_b_d      = gnt_b;
                    // Illegal opcodes still run through the ALU as a harmless add.
                    alu_ctrl_d   = gnt_illegal ? OP_ADD : gnt_op;
                    id_d         = gnt_id;
                    op_d         = gnt_op;
                    illegal_d    = gnt_illegal;
                    last_grant_d = gnt_id;
                    state_d      = ST_EXEC;
                end
            end
            // ALU samples its stable inputs at the edge ending this cycle.
            ST_EXEC: state_d = ST_CAPT;
            ST_CAPT: begin
                rsp_result_d   = capt_result;
                rsp_zero_d     = (capt_result == '0);
                rsp_overflow_d = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? alu_overflow : 1'b0;
                rsp_err_d      = illegal_q;
                rsp_id_d       = id_q;
                rsp_valid_d    = 1'b1;
                state_d        = ST_RESP;
            end
            default: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            last_grant_q   <= 1'b1;
            id_q           <= 1'b0;
            op_q           <= 3'b000;
            illegal_q      <= 1'b0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_ctrl_q     <= 3'b000;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= 1'b0;
            rsp_result_q   <= '0;
            rsp_zero_q     <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            id_q           <= id_d;
            op_q           <= op_d;
            illegal_q      <= illegal_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_ctrl_q     <= alu_ctrl_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_id_q       <= rsp_id_d;
            rsp_result_q   <= rsp_result_d;
            rsp_zero_q     <= rsp_zero_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_err_q      <= rsp_err_d;
        end
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_ctrl     = alu_ctrl_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_err      = rsp_err_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter with a behavioural registered ALU attached to the alu_* ports.
module tb_alu_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [15:0] rsp_result;
    logic        rsp_zero, rsp_overflow, rsp_err;
    logic [15:0] alu_a, alu_b;
    logic [2:0]  alu_ctrl;
    logic [15:0] alu_result;
    logic        alu_overflow, alu_slt;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    alu_arbiter #(.WIDTH(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
        .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_slt(alu_slt),
        .busy(busy)
    );

    // Registered ALU model. Overflow is reported from the subtractor for slt
    // too, and the result bus carries a marker for slt, so the arbiter must
    // mask overflow and take alu_slt itself.
    always @(posedge clock or negedge reset_n) begin
        logic [15:0] s, d;
        if (!reset_n) begin
            alu_result   <= '0;
            alu_overflow <= 1'b0;
            alu_slt      <= 1'b0;
        end else begin
            s = alu_a + alu_b;
            d = alu_a - alu_b;
            alu_slt <= ($signed(alu_a) < $signed(alu_b));
            case (alu_ctrl)
                3'b000: begin alu_result <= s; alu_overflow <= (alu_a[15] == alu_b[15]) && (s[15] != alu_a[15]); end
                3'b001: begin alu_result <= d; alu_overflow <= (alu_a[15] != alu_b[15]) && (d[15] != alu_a[15]); end
                3'b010: begin alu_result <= alu_a & alu_b; alu_overflow <= 1'b0; end
                3'b011: begin alu_result <= alu_a | alu_b; alu_overflow <= 1'b0; end
                3'b100: begin alu_result <= 16'hDEAD; alu_overflow <= (alu_a[15] != alu_b[15]) && (d[15] != alu_a[15]); end
                default: begin alu_result <= 16'hBEEF; alu_overflow <= 1'b1; end
            endcase
        end
    end

    typedef struct {
        logic        id;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        zero;
        logic        ovf;
        logic        err;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic rdy(input logic id);
        return id ? req1_ready : req0_ready;
    endfunction

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_op = 0; req1_op = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        idle_inputs();
        reset_n = 0;
        repeat (2) @(negedge clock);
        reset_n = 1;
    endtask

    // Present a request, wait (bounded) for its ready, let the edge accept it,
    // then drop valid. Returns just after the accept edge (start of EXEC).
    task automatic issue_req(input logic id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int n;
        @(negedge clock);
        if (id) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
        #1;
        n = 0;
        while (!rdy(id) && n < 12) begin @(negedge clock); #1; n++; end
        chk("req_ready", rdy(id), 1);
        @(posedge clock); #1;
        if (id) req1_valid = 0; else req0_valid = 0;
    endtask

    // Count negedges from the accept edge to rsp_valid; expected distance 3.
    task automatic wait_rsp();
        int cnt;
        cnt = 0;
        while (!rsp_valid && cnt < 12) begin @(negedge clock); cnt++; end
        chk("rsp_latency", cnt, 3);
    endtask

    task automatic handshake();
        rsp_ready = 1;
        @(posedge clock); #1;
        rsp_ready = 0;
        chk("rsp_valid_drop", rsp_valid, 0);
        chk("busy_after_rsp", busy, 0);
    endtask

    task automatic check_rsp(input string tag, input vec_t v);
        chk({tag, "_id"},     rsp_id, v.id);
        chk({tag, "_result"}, rsp_result, v.res);
        chk({tag, "_zero"},   rsp_zero, v.zero);
        chk({tag, "_ovf"},    rsp_overflow, v.ovf);
        chk({tag, "_err"},    rsp_err, v.err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [15:0] held;
        int n;

        //       id  op      a         b         res       z  o  e
        tbl[0] = '{0, 3'b000, 16'h0003, 16'h0004, 16'h0007, 0, 0, 0};
        tbl[1] = '{1, 3'b000, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0};
        tbl[2] = '{1, 3'b001, 16'h1234, 16'h1234, 16'h0000, 1, 0, 0};
        tbl[3] = '{0, 3'b100, 16'hFFFF, 16'h0001, 16'h0001, 0, 0, 0};
        tbl[4] = '{0, 3'b100, 16'h0001, 16'hFFFF, 16'h0000, 1, 0, 0};
        tbl[5] = '{1, 3'b010, 16'hF0F0, 16'h0FF0, 16'h00F0, 0, 0, 0};
        tbl[6] = '{0, 3'b011, 16'hF000, 16'h000F, 16'hF00F, 0, 0, 0};
        tbl[7] = '{1, 3'b001, 16'h8000, 16'h0001, 16'h7FFF, 0, 1, 0};
        tbl[8] = '{0, 3'b111, 16'h0005, 16'h0005, 16'h0000, 1, 0, 1};
        tbl[9] = '{1, 3'b100, 16'h8000, 16'h7FFF, 16'h0001, 0, 0, 0};

        // Reset state, with a request pending to prove ready is held low.
        idle_inputs();
        reset_n = 0;
        req0_valid = 1;
        #12;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_ctrl", alu_ctrl, 0);
        chk("rst_rsp_result", rsp_result, 0);
        req0_valid = 0;
        @(negedge clock);
        reset_n = 1;

        // Table-driven single operations.
        for (int i = 0; i < 10; i++) begin
            v = tbl[i];
            issue_req(v.id, v.op, v.a, v.b);
            chk("exec_busy", busy, 1);
            chk("exec_alu_a", alu_a, v.a);
            chk("exec_alu_b", alu_b, v.b);
            chk("exec_alu_ctrl", alu_ctrl, v.err ? 3'b000 : v.op);
            wait_rsp();
            check_rsp("vec", v);
            handshake();
            chk("alu_a_hold", alu_a, v.a);
        end

        // Arbitration: both valid continuously from reset -> 0,1,0,1.
        do_reset();
        @(negedge clock);
        req0_valid = 1; req0_op = 3'b000; req0_a = 16'h0001; req0_b = 16'h0002;
        req1_valid = 1; req1_op = 3'b000; req1_a = 16'h0010; req1_b = 16'h0020;
        for (int k = 0; k < 4; k++) begin
            #1;
            n = 0;
            while (!(req0_ready || req1_ready) && n < 12) begin @(negedge clock); #1; n++; end
            chk("arb_ready0", req0_ready, (k % 2) == 0);
            chk("arb_ready1", req1_ready, (k % 2) == 1);
            @(posedge clock); #1;
            wait_rsp();
            chk("arb_id", rsp_id, (k % 2) == 1);
            chk("arb_result", rsp_result, ((k % 2) == 1) ? 16'h0030 : 16'h0003);
            handshake();
            @(negedge clock);
        end
        req0_valid = 0; req1_valid = 0;

        // Backpressure with a competing request, then the waiting illegal op.
        issue_req(0, 3'b000, 16'h0100, 16'h0023);
        wait_rsp();
        req1_valid = 1; req1_op = 3'b110; req1_a = 16'h0009; req1_b = 16'h0009;
        held = 16'h0123;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_result", rsp_result, held);
            chk("bp_rsp_id", rsp_id, 0);
            chk("bp_req1_ready", req1_ready, 0);
            chk("bp_busy", busy, 1);
        end
        handshake();
        issue_req(1, 3'b110, 16'h0009, 16'h0009);
        chk("ill_alu_ctrl", alu_ctrl, 3'b000);
        wait_rsp();
        v = '{1, 3'b110, 16'h0009, 16'h0009, 16'h0000, 1, 0, 1};
        check_rsp("ill", v);
        handshake();

        // Reset during CAPT abandons the operation.
        issue_req(0, 3'b000, 16'h0005, 16'h0006);
        @(negedge clock);
        @(negedge clock);
        chk("pre_rst_busy", busy, 1);
        req0_valid = 1; req1_valid = 1;
        reset_n = 0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        chk("mid_rst_req0_ready", req0_ready, 0);
        chk("mid_rst_req1_ready", req1_ready, 0);
        chk("mid_rst_rsp_result", rsp_result, 0);
        req0_valid = 0; req1_valid = 0;
        @(negedge clock);
        reset_n = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            chk("no_stale_rsp", rsp_valid, 0);
        end
        req0_valid = 1; req0_op = 3'b000; req0_a = 16'h0002; req0_b = 16'h0002;
        req1_valid = 1; req1_op = 3'b000; req1_a = 16'h0040; req1_b = 16'h0001;
        #1;
        chk("post_rst_tie_r0", req0_ready, 1);
        chk("post_rst_tie_r1", req1_ready, 0);
        @(posedge clock); #1;
        req0_valid = 0; req1_valid = 0;
        wait_rsp();
        chk("post_rst_id", rsp_id, 0);
        chk("post_rst_result", rsp_result, 16'h0004);
        handshake();

        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single registered 16-bit ALU (add/sub/and/or/slt, 3-bit control, result registered on the rising clock) between two requesters.
- Each requester uses a valid/ready request and a valid/ready response.
- Round-robin arbitration; one operation in flight at a time.
- Sits between the decode/issue logic and the ALU instance. Sequences the ALU's one-cycle registered latency and packages flags per operation.

Parameters:
WIDTH, 16, operand/result width; must match the ALU instance.

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_op  in  3  ALU control code (000 add, 001 sub, 010 and, 011 or, 100 slt)
req0_a  in  WIDTH  operand A
req0_b  in  WIDTH  operand B
req1_valid, req1_ready, req1_op, req1_a, req1_b  as requester 0
rsp_valid  out  1  response available
rsp_ready  in  1  consumer takes response
rsp_id  out  1  requester index of response
rsp_result  out  WIDTH  operation result
rsp_zero  out  1  rsp_result == 0
rsp_overflow  out  1  signed overflow (add/sub only)
rsp_err  out  1  illegal opcode
alu_a, alu_b  out  WIDTH  registered ALU operands
alu_ctrl  out  3  registered ALU control
alu_result  in  WIDTH  ALU registered result
alu_overflow  in  1  ALU registered overflow
alu_slt  in  1  ALU registered SLT output
busy  out  1  state != IDLE

Behaviour:
- Reset (async, reset_n low):
  - state IDLE; last_grant=1, so requester 0 wins the first tie.
  - All outputs 0: alu_a, alu_b, alu_ctrl, rsp_*, req*_ready, busy.
  - Reset mid-operation abandons the operation; no response is produced.
- FSM states: IDLE -> EXEC -> CAPT -> RESP -> IDLE.
- IDLE:
  - reqN_ready is combinational: high only for the granted requester, and only in IDLE.
  - Grant rule: only one valid -> that one. Both valid -> the one != last_grant. Neither -> stay IDLE.
  - On the accepting edge (cycle N): register alu_a, alu_b and alu_ctrl (op, or 000 if op is illegal). Latch id, op and an illegal flag (op 101..111). last_grant<=id. Go to EXEC.
- EXEC (cycle N+1): ALU inputs stable; the ALU registers at the edge ending this cycle. Go to CAPT unconditionally.
- CAPT (cycle N+2): alu_result, alu_overflow and alu_slt are valid. At the edge, capture:
  - rsp_result = {WIDTH-1 zeros, alu_slt} for op 100; 0 if illegal; alu_result otherwise.
  - rsp_overflow = alu_overflow for op 000/001, else 0.
  - rsp_zero = (captured rsp_result == 0), computed by this block; the ALU's own zero flag is not used.
  - rsp_err = illegal flag; rsp_id = latched id.
  - Go to RESP.
- RESP:
  - rsp_valid=1 from cycle N+3. rsp_* held stable while rsp_valid && !rsp_ready.
  - On rsp_valid && rsp_ready: rsp_valid<=0, go to IDLE. A new grant is possible in the next cycle (N+4 at the earliest).
- Timing: minimum latency accept->rsp_valid is 3 cycles. Throughput is at most one operation per 4 cycles.
- Requests are not accepted outside IDLE; requesters hold valid and payload until ready.
- Illegal opcode: accepted; same timing; ALU driven with 000; rsp_result=0, rsp_zero=1, rsp_err=1, rsp_overflow=0.
- busy=1 in EXEC, CAPT and RESP.
- alu_a, alu_b and alu_ctrl hold their last values until the next grant.

Test Plan:
- Single op: req0 op=000, a=16'h0003, b=16'h0004 -> req0_ready 1 cycle; rsp_valid at +3 cycles; rsp_result=16'h0007, zero=0, overflow=0, id=0, err=0.
- Overflow/zero: req1 op=000, a=16'h7FFF, b=16'h0001 -> result 16'h8000, overflow=1. Then op=001, a=b=16'h1234 -> result 0, zero=1, overflow=0.
- SLT: op=100, a=16'hFFFF (-1), b=16'h0001 -> rsp_result=16'h0001, zero=0. Swap operands -> rsp_result=0, zero=1.
- Arbitration: both valid continuously after reset -> grants in order 0,1,0,1. Non-granted valid/payload is held and never lost.
- Backpressure/illegal: rsp_ready held low 5 cycles -> rsp_* stable, req*_ready low, busy=1. Then op=110 -> result 0, err=1, zero=1, alu_ctrl=000.
- Reset mid-op: assert reset_n low during CAPT -> all outputs 0 immediately; after release, no stale response; next tie grants requester 0.
